// File: rtl/vector_reduce_accum_unit_if.sv
// ---------------------------------------------------------------------------
// vector_reduce_accum_unit_if
//
// Bundles the beat stream, the per-chain config bus and the result stream of
// vector_reduce_accum_unit.
//   master : beat/config source, result sink (upstream stage or a testbench)
//   slave  : the reduce/accumulate unit itself
//
// Signals
//   valid_in, eof_in, chainId_in, vector_in : input beat
//   tracing, config_id, config_data         : config window and mode write
//   valid_out, eof_out, chainId_out,
//   vector_out                              : reduced/accumulated result
// ---------------------------------------------------------------------------
interface vector_reduce_accum_unit_if #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_CHAINS = 4
);
   localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

   logic                           valid_in;
   logic                           eof_in;
   logic [CW-1:0]                  chainId_in;
   logic                           tracing;
   logic [7:0]                     config_id;
   logic [7:0]                     config_data;
   logic [N-1:0][DATA_WIDTH-1:0]   vector_in;

   logic                           valid_out;
   logic                           eof_out;
   logic [CW-1:0]                  chainId_out;
   logic [N-1:0][DATA_WIDTH-1:0]   vector_out;

   modport master (
      output valid_in, eof_in, chainId_in, tracing, config_id, config_data, vector_in,
      input  valid_out, eof_out, chainId_out, vector_out
   );

   modport slave (
      input  valid_in, eof_in, chainId_in, tracing, config_id, config_data, vector_in,
      output valid_out, eof_out, chainId_out, vector_out
   );
endinterface

// File: rtl/vector_reduce_accum_unit.sv
// ---------------------------------------------------------------------------
// vector_reduce_accum_unit
//
// Reduces an N-lane vector per beat (pass, sum-all, sum-groups of N/M lanes,
// signed max-all) and optionally accumulates the reduced results of a frame
// per chain, emitting the accumulated value on the eof beat.
// Fixed 2-cycle latency, one beat per cycle, no backpressure.
//
// Ports
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : vector_reduce_accum_unit_if.slave (beat in, config bus, result out)
//
// Mode byte per chain: [1:0] reduction (0 pass, 1 sum-all, 2 sum-groups,
// 3 max-all), [2] accumulate, [7:3] ignored.
// ---------------------------------------------------------------------------
module vector_reduce_accum_unit #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_CHAINS = 4,
   parameter int M          = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   vector_reduce_accum_unit_if.slave  bus
);
   localparam int CW    = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
   localparam int GROUP = N / M;

   typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

   localparam logic [1:0] RED_PASS   = 2'd0;
   localparam logic [1:0] RED_SUM    = 2'd1;
   localparam logic [1:0] RED_GROUPS = 2'd2;
   localparam logic [1:0] RED_MAX    = 2'd3;

   // Per-chain state. Only the three meaningful mode bits are stored.
   logic [2:0]              config_byte [MAX_CHAINS];
   vec_t                    acc         [MAX_CHAINS];
   logic [MAX_CHAINS-1:0]   first;

   // Stage-1 registers
   vec_t                    vec_s1;
   logic                    valid_s1;
   logic                    eof_s1;
   logic [CW-1:0]           chain_s1;
   logic [2:0]              mode_s1;

   // Config write decode
   logic                    cfg_wr;
   logic [CW-1:0]           cfg_idx;
   logic                    unused_cfg_bits;

   assign cfg_wr          = !bus.tracing && (int'(bus.config_id) < MAX_CHAINS);
   assign cfg_idx         = bus.config_id[CW-1:0];
   assign unused_cfg_bits = ^bus.config_data[7:3];

   // ------------------------------------------------------------------
   // Stage-2 reduction
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]          sum_all;
   logic [DATA_WIDTH-1:0]          max_all;
   logic [M-1:0][DATA_WIDTH-1:0]   group_sum;
   vec_t                           reduced;

   always_comb begin
      sum_all   = '0;
      max_all   = vec_s1[0];
      group_sum = '0;
      reduced   = '0;

      for (int i = 0; i < N; i++) begin
         sum_all = sum_all + vec_s1[i];
      end
      for (int i = 1; i < N; i++) begin
         if ($signed(vec_s1[i]) > $signed(max_all)) begin
            max_all = vec_s1[i];
         end
      end
      for (int g = 0; g < M; g++) begin
         for (int j = 0; j < GROUP; j++) begin
            group_sum[g] = group_sum[g] + vec_s1[g*GROUP + j];
         end
      end

      case (mode_s1[1:0])
         RED_PASS:   reduced = vec_s1;
         RED_SUM:    reduced[0] = sum_all;
         RED_GROUPS: begin
            for (int g = 0; g < M; g++) begin
               reduced[g] = group_sum[g];
            end
         end
         RED_MAX:    reduced[0] = max_all;
         default:    reduced = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Accumulator update for the chain of the beat in stage 1
   // ------------------------------------------------------------------
   vec_t                    acc_cur;
   logic                    first_cur;
   vec_t                    acc_sum;
   logic [DATA_WIDTH-1:0]   acc_max0;
   vec_t                    acc_upd;

   assign acc_cur   = acc[chain_s1];
   assign first_cur = first[chain_s1];

   // Lane-wise wrapping sum; a first beat starts from zero so stale
   // accumulator contents never leak into a new frame.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_acc_lane
         assign acc_sum[gi] = (first_cur ? '0 : acc_cur[gi]) + reduced[gi];
      end
   endgenerate

   assign acc_max0 = first_cur                                   ? reduced[0] :
                     ($signed(reduced[0]) > $signed(acc_cur[0])) ? reduced[0] :
                                                                   acc_cur[0];

   always_comb begin
      acc_upd = acc_sum;
      if (mode_s1[1:0] == RED_MAX) begin
         acc_upd    = '0;
         acc_upd[0] = acc_max0;
      end
   end

   // ------------------------------------------------------------------
   // Sequential state: stage 1, stage 2 outputs, accumulators, config
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < MAX_CHAINS; c++) begin
            config_byte[c] <= '0;
            acc[c]         <= '0;
         end
         first           <= '1;
         vec_s1          <= '0;
         valid_s1        <= 1'b0;
         eof_s1          <= 1'b0;
         chain_s1        <= '0;
         mode_s1         <= '0;
         bus.valid_out   <= 1'b0;
         bus.eof_out     <= 1'b0;
         bus.chainId_out <= '0;
         bus.vector_out  <= '0;
      end else begin
         // Stage 1: the mode is sampled here, so a config write in the
         // same cycle only affects later beats.
         vec_s1   <= bus.vector_in;
         valid_s1 <= bus.valid_in;
         eof_s1   <= bus.eof_in;
         chain_s1 <= bus.chainId_in;
         mode_s1  <= config_byte[bus.chainId_in];

         // Stage 2
         bus.valid_out <= 1'b0;
         if (valid_s1) begin
            if (!mode_s1[2]) begin
               bus.valid_out   <= 1'b1;
               bus.eof_out     <= eof_s1;
               bus.chainId_out <= chain_s1;
               bus.vector_out  <= reduced;
            end else if (eof_s1) begin
               bus.valid_out    <= 1'b1;
               bus.eof_out      <= 1'b1;
               bus.chainId_out  <= chain_s1;
               bus.vector_out   <= acc_upd;
               acc[chain_s1]    <= '0;
               first[chain_s1]  <= 1'b1;
            end else begin
               bus.eof_out      <= 1'b0;
               acc[chain_s1]    <= acc_upd;
               first[chain_s1]  <= 1'b0;
            end
         end

         // A config write restarts that chain's frame; it is placed last
         // so it wins over a same-cycle accumulator update of that chain.
         if (cfg_wr) begin
            config_byte[cfg_idx] <= bus.config_data[2:0];
            acc[cfg_idx]         <= '0;
            first[cfg_idx]       <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vector_reduce_accum_unit.sv
// ---------------------------------------------------------------------------
// tb_vector_reduce_accum_unit
//
// Directed bench for vector_reduce_accum_unit: a table of single-beat
// vectors for the non-accumulating modes, followed by hand-written
// multi-beat sequences (accumulated max, interleaved chains, reset
// mid-frame, ignored config writes, same-cycle config write).
// ---------------------------------------------------------------------------
module tb_vector_reduce_accum_unit;
   localparam int N  = 8;
   localparam int DW = 32;
   localparam int MC = 4;
   localparam int M  = 2;

   typedef logic [N-1:0][DW-1:0] vec_t;

   typedef struct {
      logic       valid;
      logic       eof;
      logic [1:0] chain;
      vec_t       vec;
      logic       exp_valid;
      logic       exp_eof;
      vec_t       exp_vec;
   } beat_t;

   logic clk;
   logic rst;

   vector_reduce_accum_unit_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) bus ();

   vector_reduce_accum_unit #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .M(M)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   beat_t seq_q [$];
   beat_t tbl [10];

   function automatic vec_t mk8(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7);
      vec_t v;
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
      v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
      return v;
   endfunction

   function automatic beat_t mkb(input logic valid, input logic eof, input logic [1:0] chain,
                                 input vec_t vec, input logic exp_valid, input logic exp_eof,
                                 input vec_t exp_vec);
      beat_t b;
      b.valid = valid; b.eof = eof; b.chain = chain; b.vec = vec;
      b.exp_valid = exp_valid; b.exp_eof = exp_eof; b.exp_vec = exp_vec;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic check_chain(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input vec_t act, input vec_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input beat_t b);
      bus.valid_in   = b.valid;
      bus.eof_in     = b.eof;
      bus.chainId_in = b.chain;
      bus.vector_in  = b.vec;
   endtask

   task automatic drive_idle();
      bus.valid_in = 1'b0;
      bus.eof_in   = 1'b0;
   endtask

   task automatic check_beat(input string name, input beat_t b);
      check_bit({name, ".valid_out"}, bus.valid_out, b.exp_valid);
      if (b.exp_valid) begin
         check_bit({name, ".eof_out"}, bus.eof_out, b.exp_eof);
         check_chain({name, ".chainId_out"}, bus.chainId_out, b.chain);
         check_vec({name, ".vector_out"}, bus.vector_out, b.exp_vec);
      end
      $display("beat %s chain=%0d valid_out=%0b eof_out=%0b out0=%h", name, b.chain,
               bus.valid_out, bus.eof_out, bus.vector_out[0]);
   endtask

   task automatic cfg(input logic [7:0] id, input logic [7:0] data);
      bus.tracing     = 1'b0;
      bus.config_id   = id;
      bus.config_data = data;
      tick();
      bus.tracing     = 1'b1;
      bus.config_id   = 8'hFF;
   endtask

   // Back-to-back beats; the result of beat k is visible after tick k+2.
   task automatic run_seq(input string name);
      for (int t = 0; t <= seq_q.size(); t++) begin
         if (t < seq_q.size()) drive(seq_q[t]);
         else                  drive_idle();
         tick();
         if (t >= 1) check_beat($sformatf("%s[%0d]", name, t - 1), seq_q[t - 1]);
      end
      seq_q.delete();
   endtask

   task automatic check_reset_state(input string name);
      check_bit({name, ".valid_out"}, bus.valid_out, 1'b0);
      check_bit({name, ".eof_out"}, bus.eof_out, 1'b0);
      check_chain({name, ".chainId_out"}, bus.chainId_out, 2'd0);
      check_vec({name, ".vector_out"}, bus.vector_out, '0);
   endtask

   vec_t z;
   vec_t v18;
   vec_t vff;

   initial begin
      z   = '0;
      v18 = mk8(1, 2, 3, 4, 5, 6, 7, 8);
      vff = mk8(-1, -1, -1, -1, -1, -1, -1, -1);

      // Non-accumulating vectors: chain0 pass, chain1 sum-all,
      // chain2 sum-groups, chain3 signed max-all.
      tbl[0] = mkb(1, 0, 0, v18, 1, 0, v18);
      tbl[1] = mkb(1, 0, 1, v18, 1, 0, mk8(36, 0, 0, 0, 0, 0, 0, 0));
      tbl[2] = mkb(1, 1, 1, vff, 1, 1, mk8(32'hFFFFFFF8, 0, 0, 0, 0, 0, 0, 0));
      tbl[3] = mkb(1, 0, 2, v18, 1, 0, mk8(10, 26, 0, 0, 0, 0, 0, 0));
      tbl[4] = mkb(1, 0, 2, mk8(-1, -2, -3, -4, 5, 6, 7, 8), 1, 0, mk8(-10, 26, 0, 0, 0, 0, 0, 0));
      tbl[5] = mkb(1, 0, 3, mk8(-5, 3, -7, 2, 0, -1, 100, -100), 1, 0, mk8(100, 0, 0, 0, 0, 0, 0, 0));
      tbl[6] = mkb(1, 0, 3, mk8(-5, -2, -9, -3, -100, -7, -8, -6), 1, 0, mk8(-2, 0, 0, 0, 0, 0, 0, 0));
      tbl[7] = mkb(1, 0, 3, mk8(32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0), 1, 0,
                   mk8(32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0));
      tbl[8] = mkb(0, 0, 1, v18, 0, 0, z);
      tbl[9] = mkb(1, 0, 1, mk8(10, -1, 2, -2, 3, -3, 4, -4), 1, 0, mk8(9, 0, 0, 0, 0, 0, 0, 0));

      rst             = 1'b1;
      bus.valid_in    = 1'b0;
      bus.eof_in      = 1'b0;
      bus.chainId_in  = '0;
      bus.vector_in   = '0;
      bus.tracing     = 1'b1;
      bus.config_id   = 8'hFF;
      bus.config_data = 8'h00;
      tick(); tick(); tick();
      check_reset_state("reset");
      rst = 1'b0;
      tick();

      cfg(8'd0, 8'h00);
      cfg(8'd1, 8'h01);
      cfg(8'd2, 8'h02);
      cfg(8'd3, 8'h03);

      for (int t = 0; t <= 10; t++) begin
         if (t < 10) drive(tbl[t]);
         else        drive_idle();
         tick();
         if (t >= 1) check_beat($sformatf("tbl[%0d]", t - 1), tbl[t - 1]);
      end

      // Accumulated signed max on chain 2, then a single-beat frame that
      // must not see the previous frame's maximum.
      cfg(8'd2, 8'h07);
      seq_q.push_back(mkb(1, 0, 2, mk8(-5, -6, -7, -8, -10, -20, -30, -40), 0, 0, z));
      seq_q.push_back(mkb(1, 0, 2, mk8(-3, -2, -4, -50, -60, -70, -80, -90), 0, 0, z));
      seq_q.push_back(mkb(1, 1, 2, mk8(-9, -10, -11, -12, -13, -14, -15, -16), 1, 1,
                          mk8(-2, 0, 0, 0, 0, 0, 0, 0)));
      seq_q.push_back(mkb(1, 1, 2, mk8(-100, -200, -300, -400, -500, -600, -700, -800), 1, 1,
                          mk8(-100, 0, 0, 0, 0, 0, 0, 0)));
      run_seq("accmax");

      // Interleaved accumulation on chains 0 and 3.
      cfg(8'd0, 8'h05);
      cfg(8'd3, 8'h05);
      seq_q.push_back(mkb(1, 0, 0, mk8(1, 0, 0, 0, 0, 0, 0, 0), 0, 0, z));
      seq_q.push_back(mkb(1, 0, 3, mk8(1, 2, 3, 4, 0, 0, 0, 0), 0, 0, z));
      seq_q.push_back(mkb(1, 1, 0, mk8(0, 0, 0, 0, 0, 0, 0, 2), 1, 1, mk8(3, 0, 0, 0, 0, 0, 0, 0)));
      seq_q.push_back(mkb(1, 1, 3, mk8(5, 5, 5, 5, 0, 0, 0, 0), 1, 1, mk8(30, 0, 0, 0, 0, 0, 0, 0)));
      run_seq("interleave");

      // Reset mid-frame on chain 0 discards the partial sum and the mode.
      seq_q.push_back(mkb(1, 0, 0, mk8(2, 0, 0, 0, 0, 0, 0, 0), 0, 0, z));
      seq_q.push_back(mkb(1, 0, 0, mk8(3, 0, 0, 0, 0, 0, 0, 0), 0, 0, z));
      run_seq("prerst");
      rst = 1'b1;
      tick(); tick();
      check_reset_state("midrst");
      rst = 1'b0;
      tick();
      seq_q.push_back(mkb(1, 1, 0, mk8(7, 0, 0, 0, 0, 0, 0, 0), 1, 1, mk8(7, 0, 0, 0, 0, 0, 0, 0)));
      seq_q.push_back(mkb(1, 0, 0, v18, 1, 0, v18));
      run_seq("postrst");

      // Ignored writes: tracing=1, and an out-of-range chain index.
      cfg(8'd1, 8'h01);
      bus.tracing     = 1'b1;
      bus.config_id   = 8'd1;
      bus.config_data = 8'h03;
      tick();
      bus.tracing     = 1'b0;
      bus.config_id   = 8'd4;
      bus.config_data = 8'h03;
      tick();
      bus.tracing     = 1'b1;
      bus.config_id   = 8'hFF;
      seq_q.push_back(mkb(1, 0, 1, v18, 1, 0, mk8(36, 0, 0, 0, 0, 0, 0, 0)));
      seq_q.push_back(mkb(1, 0, 0, v18, 1, 0, v18));
      run_seq("ignwr");

      // A beat in the same cycle as its chain's config write uses the old mode.
      drive(mkb(1, 0, 1, v18, 0, 0, z));
      bus.tracing     = 1'b0;
      bus.config_id   = 8'd1;
      bus.config_data = 8'h00;
      tick();
      drive_idle();
      bus.tracing   = 1'b1;
      bus.config_id = 8'hFF;
      tick();
      check_beat("samecyc", mkb(1, 0, 1, v18, 1, 0, mk8(36, 0, 0, 0, 0, 0, 0, 0)));
      seq_q.push_back(mkb(1, 0, 1, v18, 1, 0, v18));
      run_seq("newmode");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
